roberts_cross_unary_core: RTL and testbench
===========================================

Name: roberts_cross_unary_core

Overview:
Multi-channel deterministic unary Roberts cross engine for the img_proc arch sweep. Per channel it computes sat(|p00-p11| + |p01-p10|) by streaming thermometer codes of the four pixels against a shared ramp counter and accumulating XOR pulses. It adds data-dependent early exit and a programmable cycle budget for MAE sweeps, with a start/busy/done handshake. It replaces the single-channel, fixed-width core driven by the top-level bench.

Parameters:
DATA_WIDTH, 8, pixel/result width per channel
NUM_CH, 4, parallel channels sharing one ramp counter
EARLY_EXIT, 1, 1 = stop once ramp passes largest latched pixel; 0 = always full 2^DATA_WIDTH cycles
CNT_W, DATA_WIDTH+1, width of ramp/cycle counters and budget

Ports:
gclk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  request; sampled only in IDLE
cycle_budget  in  CNT_W  max RUN cycles; 0 = unlimited; latched on start
pix00  in  NUM_CH*DATA_WIDTH  top-left pixels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
pix01  in  NUM_CH*DATA_WIDTH  top-right pixels
pix10  in  NUM_CH*DATA_WIDTH  bottom-left pixels
pix11  in  NUM_CH*DATA_WIDTH  bottom-right pixels
busy  out  1  high in RUN and DONE
op_finished  out  1  one-cycle done pulse
data_out  out  NUM_CH*DATA_WIDTH  per-channel saturated result
saturated  out  NUM_CH  per-channel saturation flag
cycle_count  out  CNT_W  RUN cycles executed for the last operation

Behaviour:
- Reset (rst_n low, any state, including mid-RUN): state IDLE; busy, op_finished, data_out, saturated, cycle_count, ramp k, accumulators all 0. Operation in flight is discarded.
- States: IDLE -> RUN on start; RUN -> DONE on terminate; DONE -> IDLE unconditionally. start while busy ignored; pixels/budget ignored outside start.
- On start in IDLE: latch all pixels and cycle_budget, k=0, accumulators 0, cycle_count 0. Latched max M = maximum over all 4*NUM_CH pixels (computed at latch).
- RUN, per cycle at ramp value k: per channel, ex=(p00>k)^(p11>k), ey=(p01>k)^(p10>k); acc += ex+ey, saturating at 2^DATA_WIDTH-1 (saturated flag sticky for op once sum would exceed). k++, cycle_count++.
- Terminate after the current RUN cycle when any: k == 2^DATA_WIDTH-1; EARLY_EXIT and k+1 >= M (M=0 ends after one cycle); budget!=0 and cycle_count+1 == budget.
- DONE: op_finished=1 exactly one cycle; data_out/saturated/cycle_count update to final values on entering DONE and hold until next start accepted.
- Latency: start sampled at edge E; N RUN cycles; op_finished high in cycle following edge E+N+1. Next start accepted earliest 1 cycle after op_finished.
- Exactness: result exact iff run not budget-truncated; EARLY_EXIT never changes result.

Decomposition:
- Package roberts_cross_pkg: state enum {IDLE, RUN, DONE}; function satadd; localparam MAX_VAL = 2^DATA_WIDTH-1.
- Sub-module roberts_cross_lane (one per channel via generate): latched pixels, two comparator pairs, XOR, saturating accumulator, sat flag; inputs k, clear, en.
- Top holds FSM, ramp counter, budget compare, max-of-pixels reduction.

Test Plan:
- W=8, ch0 p00=200,p11=10,p01=50,p10=60, others 0, budget 0, EARLY_EXIT=1 -> data_out ch0=200, sat=0, cycle_count=200, one op_finished pulse.
- Same with EARLY_EXIT=0 -> data_out ch0=200, cycle_count=256.
- Same with budget=100 -> ch0=100 (90+10), cycle_count=100.
- ch1 p00=255,p11=0,p01=255,p10=0 -> ch1=255, saturated[1]=1, cycle_count=255; other channels 0, unsaturated.
- All pixels 0 -> every channel 0, cycle_count=1; start pulsed during RUN of a long op -> ignored, single op_finished.
- rst_n low at RUN cycle 50, then release and restart with first vector -> all outputs 0 during reset; rerun yields 200/200 cycles.

Source files
------------

// File: rtl/roberts_cross_pkg.sv
// roberts_cross_pkg: shared state encoding and saturating-add helper for the unary Roberts cross core
package roberts_cross_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int PKG_DATA_WIDTH = 8;
    localparam int MAX_VAL = (1 << PKG_DATA_WIDTH) - 1;
    function automatic logic [31:0] satadd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
        return (a + b > max) ? max : a + b;
    endfunction
endpackage

// File: rtl/roberts_cross_lane.sv
// roberts_cross_lane: one channel of latched pixels, thermometer compare/XOR and saturating accumulator
module roberts_cross_lane
    import roberts_cross_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  gclk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_k,
    input  logic [DATA_WIDTH-1:0] i_p00,
    input  logic [DATA_WIDTH-1:0] i_p01,
    input  logic [DATA_WIDTH-1:0] i_p10,
    input  logic [DATA_WIDTH-1:0] i_p11,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic                  o_sat
);
    localparam logic [31:0] MAXV = (32'd1 << DATA_WIDTH) - 32'd1;
    logic [DATA_WIDTH-1:0] r_p00, r_p01, r_p10, r_p11, r_acc;
    logic                  r_sat;
    logic                  w_ex, w_ey;
    logic [31:0]           w_inc;
    // each pixel becomes a thermometer bit against the ramp; the XOR counts ramp steps between the pair
    assign w_ex  = (r_p00 > i_k) ^ (r_p11 > i_k);
    assign w_ey  = (r_p01 > i_k) ^ (r_p10 > i_k);
    assign w_inc = 32'(w_ex) + 32'(w_ey);
    assign o_acc = r_acc;
    assign o_sat = r_sat;
    // latch pixels on clear, accumulate pulses while enabled, sticky flag once the sum would overflow
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            r_p00 <= '0;
            r_p01 <= '0;
            r_p10 <= '0;
            r_p11 <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clear) begin
            r_p00 <= i_p00;
            r_p01 <= i_p01;
            r_p10 <= i_p10;
            r_p11 <= i_p11;
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= DATA_WIDTH'(satadd(32'(r_acc), w_inc, MAXV));
            if (32'(r_acc) + w_inc > MAXV) r_sat <= 1'b1;
        end
    end
endmodule

// File: rtl/roberts_cross_unary_core.sv
// roberts_cross_unary_core: multi-channel unary Roberts cross with shared ramp, early exit and cycle budget
module roberts_cross_unary_core
    import roberts_cross_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = DATA_WIDTH + 1
) (
    input  logic                         gclk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cycle_budget,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pix00,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pix01,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pix10,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pix11,
    output logic                         busy,
    output logic                         op_finished,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            saturated,
    output logic [CNT_W-1:0]             cycle_count
);
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_k, r_max;
    logic [CNT_W-1:0]      r_cnt, r_budget;
    logic                  r_busy, r_done;
    logic [DATA_WIDTH-1:0] w_max;
    logic                  w_start, w_run, w_last;
    assign w_start     = start && (r_state == IDLE);
    assign w_run       = (r_state == RUN);
    assign busy        = r_busy;
    assign op_finished = r_done;
    assign cycle_count = r_cnt;
    // largest of every pixel in every channel bounds the useful ramp length
    always_comb begin
        w_max = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_max = (pix00[i*DATA_WIDTH +: DATA_WIDTH] > w_max) ? pix00[i*DATA_WIDTH +: DATA_WIDTH] : w_max;
            w_max = (pix01[i*DATA_WIDTH +: DATA_WIDTH] > w_max) ? pix01[i*DATA_WIDTH +: DATA_WIDTH] : w_max;
            w_max = (pix10[i*DATA_WIDTH +: DATA_WIDTH] > w_max) ? pix10[i*DATA_WIDTH +: DATA_WIDTH] : w_max;
            w_max = (pix11[i*DATA_WIDTH +: DATA_WIDTH] > w_max) ? pix11[i*DATA_WIDTH +: DATA_WIDTH] : w_max;
        end
    end
    // the current RUN cycle is the last one on ramp end, ramp past every pixel, or budget reached
    always_comb begin
        w_last = (r_k == {DATA_WIDTH{1'b1}})
               || ((EARLY_EXIT != 0) && (CNT_W'(r_k) + CNT_W'(1) >= CNT_W'(r_max)))
               || ((r_budget != '0) && (r_cnt + CNT_W'(1) == r_budget));
    end
    // control FSM: IDLE waits for start, RUN steps the ramp, DONE raises the finish pulse
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_max    <= '0;
            r_cnt    <= '0;
            r_budget <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state  <= RUN;
                    r_k      <= '0;
                    r_cnt    <= '0;
                    r_max    <= w_max;
                    r_budget <= cycle_budget;
                    r_busy   <= 1'b1;
                end
                RUN: begin
                    r_k   <= r_k + DATA_WIDTH'(1);
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            roberts_cross_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .gclk    (gclk),
                .rst_n   (rst_n),
                .i_clear (w_start),
                .i_en    (w_run),
                .i_k     (r_k),
                .i_p00   (pix00[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_p01   (pix01[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_p10   (pix10[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_p11   (pix11[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_acc   (data_out[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_sat   (saturated[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_roberts_cross_unary_core.sv
// tb_roberts_cross_unary_core: directed checks of the unary Roberts cross core
module tb_roberts_cross_unary_core;
    logic        gclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic [8:0]  cycle_budget = '0;
    logic [31:0] pix00 = '0, pix01 = '0, pix10 = '0, pix11 = '0;
    logic        busy, op_finished, b_busy, b_op_finished;
    logic [31:0] data_out, b_data_out;
    logic [3:0]  saturated, b_saturated;
    logic [8:0]  cycle_count, b_cycle_count;
    int total = 0;
    int bad = 0;

    always #5 gclk = ~gclk;

    roberts_cross_unary_core #(.DATA_WIDTH(8), .NUM_CH(4), .EARLY_EXIT(1)) dut (
        .gclk(gclk), .rst_n(rst_n), .start(start), .cycle_budget(cycle_budget),
        .pix00(pix00), .pix01(pix01), .pix10(pix10), .pix11(pix11),
        .busy(busy), .op_finished(op_finished), .data_out(data_out),
        .saturated(saturated), .cycle_count(cycle_count)
    );

    roberts_cross_unary_core #(.DATA_WIDTH(8), .NUM_CH(4), .EARLY_EXIT(0)) dut_b (
        .gclk(gclk), .rst_n(rst_n), .start(start_b), .cycle_budget(cycle_budget),
        .pix00(pix00), .pix01(pix01), .pix10(pix10), .pix11(pix11),
        .busy(b_busy), .op_finished(b_op_finished), .data_out(b_data_out),
        .saturated(b_saturated), .cycle_count(b_cycle_count)
    );

    task automatic set_pix(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        pix00[ch*8 +: 8] = a;
        pix01[ch*8 +: 8] = b;
        pix10[ch*8 +: 8] = c;
        pix11[ch*8 +: 8] = d;
    endtask

    task automatic clear_pix;
        pix00 = '0; pix01 = '0; pix10 = '0; pix11 = '0;
    endtask

    task automatic pulse_start;
        @(negedge gclk) start = 1'b1;
        @(negedge gclk) start = 1'b0;
    endtask

    task automatic wait_a(input int inject, output int first, output int pulses);
        first = -1;
        pulses = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge gclk);
            start = (c == inject);
            if (op_finished) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_b(output int first, output int pulses);
        first = -1;
        pulses = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge gclk);
            if (b_op_finished) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge gclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (op_finished !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", op_finished); end
        total++; if (data_out !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
        total++; if (saturated !== 4'd0) begin bad++; $display("FAIL reset_sat got=%b want=0", saturated); end
        total++; if (cycle_count !== 9'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cycle_count); end
        @(negedge gclk) rst_n = 1'b1;
    endtask

    task automatic test_early_exit;
        int first, pulses;
        clear_pix(); set_pix(0, 200, 50, 60, 10); cycle_budget = 0;
        pulse_start();
        wait_a(0, first, pulses);
        total++; if (data_out[7:0] !== 8'd200) begin bad++; $display("FAIL ee_data got=%0d want=200", data_out[7:0]); end
        total++; if (saturated !== 4'd0) begin bad++; $display("FAIL ee_sat got=%b want=0000", saturated); end
        total++; if (cycle_count !== 9'd200) begin bad++; $display("FAIL ee_cnt got=%0d want=200", cycle_count); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL ee_pulses got=%0d want=1", pulses); end
        total++; if (first !== 201) begin bad++; $display("FAIL ee_latency got=%0d want=201", first); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ee_busy_after got=%0b want=0", busy); end
    endtask

    task automatic test_full_range;
        int first, pulses;
        clear_pix(); set_pix(0, 200, 50, 60, 10); cycle_budget = 0;
        @(negedge gclk) start_b = 1'b1;
        @(negedge gclk) start_b = 1'b0;
        wait_b(first, pulses);
        total++; if (b_data_out[7:0] !== 8'd200) begin bad++; $display("FAIL full_data got=%0d want=200", b_data_out[7:0]); end
        total++; if (b_cycle_count !== 9'd256) begin bad++; $display("FAIL full_cnt got=%0d want=256", b_cycle_count); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL full_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_budget;
        int first, pulses;
        clear_pix(); set_pix(0, 200, 50, 60, 10); cycle_budget = 100;
        pulse_start();
        cycle_budget = 0;
        wait_a(0, first, pulses);
        total++; if (data_out[7:0] !== 8'd100) begin bad++; $display("FAIL budget_data got=%0d want=100", data_out[7:0]); end
        total++; if (cycle_count !== 9'd100) begin bad++; $display("FAIL budget_cnt got=%0d want=100", cycle_count); end
        total++; if (first !== 101) begin bad++; $display("FAIL budget_latency got=%0d want=101", first); end
    endtask

    task automatic test_saturation;
        int first, pulses;
        clear_pix(); set_pix(1, 255, 255, 0, 0); cycle_budget = 0;
        pulse_start();
        wait_a(0, first, pulses);
        total++; if (data_out[15:8] !== 8'd255) begin bad++; $display("FAIL sat_data got=%0d want=255", data_out[15:8]); end
        total++; if (saturated !== 4'b0010) begin bad++; $display("FAIL sat_flags got=%b want=0010", saturated); end
        total++; if (cycle_count !== 9'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", cycle_count); end
        total++; if ((data_out & 32'hFFFF00FF) !== 32'd0) begin bad++; $display("FAIL sat_others got=%h want=0", data_out); end
    endtask

    task automatic test_zero;
        int first, pulses;
        clear_pix(); cycle_budget = 0;
        pulse_start();
        wait_a(0, first, pulses);
        total++; if (data_out !== 32'd0) begin bad++; $display("FAIL zero_data got=%h want=0", data_out); end
        total++; if (cycle_count !== 9'd1) begin bad++; $display("FAIL zero_cnt got=%0d want=1", cycle_count); end
        total++; if (first !== 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", first); end
    endtask

    task automatic test_start_ignored;
        int first, pulses;
        clear_pix(); set_pix(0, 200, 50, 60, 10); cycle_budget = 0;
        pulse_start();
        clear_pix();
        wait_a(20, first, pulses);
        total++; if (pulses !== 1) begin bad++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
        total++; if (data_out[7:0] !== 8'd200) begin bad++; $display("FAIL ign_data got=%0d want=200", data_out[7:0]); end
        total++; if (cycle_count !== 9'd200) begin bad++; $display("FAIL ign_cnt got=%0d want=200", cycle_count); end
    endtask

    task automatic test_reset_mid_run;
        int first, pulses;
        clear_pix(); set_pix(0, 200, 50, 60, 10); cycle_budget = 0;
        pulse_start();
        repeat (49) @(negedge gclk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
        total++; if (data_out !== 32'd0) begin bad++; $display("FAIL mid_data got=%h want=0", data_out); end
        total++; if (cycle_count !== 9'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", cycle_count); end
        @(negedge gclk);
        total++; if (op_finished !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", op_finished); end
        rst_n = 1'b1;
        pulse_start();
        wait_a(0, first, pulses);
        total++; if (data_out[7:0] !== 8'd200) begin bad++; $display("FAIL rerun_data got=%0d want=200", data_out[7:0]); end
        total++; if (cycle_count !== 9'd200) begin bad++; $display("FAIL rerun_cnt got=%0d want=200", cycle_count); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL rerun_pulses got=%0d want=1", pulses); end
    endtask

    initial begin
        test_reset();
        test_early_exit();
        test_full_range();
        test_budget();
        test_saturation();
        test_zero();
        test_start_ignored();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
